// File: rtl/fifo_rd_packer_pkg.sv
// fifo_rd_packer shared types and helpers.
// State encoding, counter width and lane keep-mask generation.
package fifo_rd_packer_pkg;

    localparam int DEF_WIDTH_FIFO  = 8;
    localparam int DEF_PACK_NUM    = 4;
    localparam int DEF_TIMEOUT_CYC = 16;
    localparam int CNT_W           = $clog2(DEF_PACK_NUM + 1);
    localparam int MAX_LANES       = 64;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } pack_state_e;

    function automatic logic [MAX_LANES-1:0] keep_mask(input int unsigned n);
        logic [MAX_LANES:0] m;
        m = ((MAX_LANES+1)'(1) << n) - (MAX_LANES+1)'(1);
        return m[MAX_LANES-1:0];
    endfunction

endpackage

// File: rtl/fifo_rd_packer_idle_timer.sv
// Idle counter for fifo_rd_packer partial-word auto flush.
// Built only when FIFO_RD_PACKER_TIMEOUT_EN is defined.
module pack_idle_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk_r,
    input  logic rst,
    input  logic idle,
    output logic expire
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] cnt_q;

    assign expire = idle && (cnt_q == LAST);

    // count consecutive idle cycles, restart on activity or expiry
    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (!idle || expire) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// FIFO read-side lane packer with valid/ready output register.
// Optional idle auto flush: define FIFO_RD_PACKER_TIMEOUT_EN.
module fifo_rd_packer
    import fifo_rd_packer_pkg::*;
#(
    parameter int WIDTH_FIFO  = DEF_WIDTH_FIFO,
    parameter int PACK_NUM    = DEF_PACK_NUM,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                           clk_r,
    input  logic                           rst,
    input  logic                           empty,
    output logic                           ren,
    input  logic [WIDTH_FIFO-1:0]          rdata,
    input  logic                           flush_req,
    output logic                           flush_done,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH_FIFO*PACK_NUM-1:0] out_data,
    output logic [PACK_NUM-1:0]            out_keep
);

    localparam int CW = (PACK_NUM == DEF_PACK_NUM) ? CNT_W
                                                   : $clog2(PACK_NUM + 1);
    localparam int DW = WIDTH_FIFO * PACK_NUM;
    localparam logic [CW-1:0] CNT_FULL = CW'(PACK_NUM);

    pack_state_e state_q;
    pack_state_e state_d;

    logic [CW-1:0]       cnt_q;
    logic [CW-1:0]       cnt_nxt;
    logic                rd_pend_q;
    logic                flush_pend_q;
    logic [DW-1:0]       acc_q;
    logic                out_valid_q;
    logic [DW-1:0]       out_data_q;
    logic [PACK_NUM-1:0] out_keep_q;
    logic                xfer;
    logic                timeout_hit;
    logic [PACK_NUM-1:0] keep_now;
    logic [DW-1:0]       data_mask;

    assign cnt_nxt = cnt_q + CW'(rd_pend_q);

    assign ren = !empty && (state_q == FILL) && !flush_pend_q &&
                 (({1'b0, cnt_q} + {{CW{1'b0}}, rd_pend_q}) <
                  (CW+1)'(PACK_NUM));

    assign xfer = ((state_q == HOLD) || (state_q == EMIT)) &&
                  (!out_valid_q || out_ready);

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_keep  = out_keep_q;

`ifdef FIFO_RD_PACKER_TIMEOUT_EN
    logic idle;

    assign idle = (state_q == FILL) && (cnt_q != '0) && !rd_pend_q && empty;

    pack_idle_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_idle_timer (
        .clk_r  (clk_r),
        .rst    (rst),
        .idle   (idle),
        .expire (timeout_hit)
    );
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC > 0);
    assign timeout_hit    = 1'b0;
`endif

    // keep mask and matching bit mask for the lanes filled so far
    always_comb begin
        logic [MAX_LANES-1:0] km;
        km        = keep_mask(32'(cnt_q));
        keep_now  = km[PACK_NUM-1:0];
        data_mask = '0;
        for (int i = 0; i < PACK_NUM; i++) begin
            data_mask[i*WIDTH_FIFO +: WIDTH_FIFO] = {WIDTH_FIFO{keep_now[i]}};
        end
    end

    // next-state and flush completion pulse
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        unique case (state_q)
            FILL: begin
                if (cnt_nxt == CNT_FULL) begin
                    state_d = HOLD;
                end else if (flush_pend_q) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (xfer) begin
                    state_d = flush_pend_q ? DRAIN : FILL;
                end
            end
            DRAIN: begin
                if (!rd_pend_q) begin
                    if (cnt_q == '0) begin
                        flush_done = 1'b1;
                        state_d    = FILL;
                    end else begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (xfer) begin
                    flush_done = 1'b1;
                    state_d    = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // state, read-pending and flush-pending registers
    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            state_q      <= FILL;
            rd_pend_q    <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= ren;
            if (flush_done) begin
                flush_pend_q <= 1'b0;
            end else if (flush_req || timeout_hit) begin
                flush_pend_q <= 1'b1;
            end
        end
    end

    // lane capture into the accumulator, cleared when a word leaves
    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (xfer) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else if (rd_pend_q) begin
            acc_q[cnt_q*WIDTH_FIFO +: WIDTH_FIFO] <= rdata;
            cnt_q <= cnt_nxt;
        end
    end

    // output register: load on xfer, drop valid once accepted
    always_ff @(posedge clk_r or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= acc_q & data_mask;
            out_keep_q  <= keep_now;
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule
